// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display interface.
// Segment bits are active-low; the hex table holds the lit patterns for 0..F.
package sevenseg_pkg;

   localparam int unsigned DIGITS    = 4;
   localparam int unsigned IDX_W     = $clog2(DIGITS);
   localparam int unsigned SEG_BUS_W = 8;
   localparam int unsigned SEG_PAT_W = 7;
   localparam int unsigned NIBBLE_W  = 4;
   localparam int unsigned HEX_CODES = 16;
   localparam int unsigned DATA_W    = DIGITS * NIBBLE_W;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam logic [SEG_PAT_W-1:0] SEG_BLANK = 7'h7F;

   // Entry i is the active-low a..g pattern that displays hex digit i.
   localparam logic [HEX_CODES-1:0][SEG_PAT_W-1:0] HEX_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   typedef struct packed {
      logic [NIBBLE_W-1:0] value;
      logic                dp;
      logic                blank;
      logic                illegal;
   } digit_t;

   // Exactly one anode driven low selects a digit.
   function automatic logic sel_valid(input logic [DIGITS-1:0] a);
      return ($countones(~a) == 1);
   endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational decode of an active-low a..g pattern into a hex value,
// flagging the all-off blank pattern and anything outside the hex table.
module seven_segment_decode
   import sevenseg_pkg::*;
(
   input  logic [SEG_PAT_W-1:0] pattern,
   output logic [NIBBLE_W-1:0]  value,
   output logic                 blank,
   output logic                 illegal
);

   logic hit;

   // Table entries are unique, so at most one iteration matches.
   always_comb begin
      value = '0;
      hit   = 1'b0;
      for (int unsigned i = 0; i < HEX_CODES; i++) begin
         if (pattern == HEX_TABLE[NIBBLE_W'(i)]) begin
            value = NIBBLE_W'(i);
            hit   = 1'b1;
         end
      end
      blank   = (pattern == SEG_BLANK);
      illegal = !hit && !blank;
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Monitors a multiplexed seven-segment bus, filters switching ghosts and
// publishes a coherent four-digit frame once every digit has been captured.
module seven_segment_capture
   import sevenseg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIGITS-1:0]    anode,
   input  logic [SEG_BUS_W-1:0] segment,
   output logic [DATA_W-1:0]    dataOut,
   output logic [DIGITS-1:0]    pointOut,
   output logic [DIGITS-1:0]    blankOut,
   output logic [DIGITS-1:0]    illegalOut,
   output logic                 frameValid,
   output logic                 stalled
);

   localparam int unsigned STABLE_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
   localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(STABLE_CYCLES);
   localparam logic [IDLE_W-1:0]   IDLE_MAX    = IDLE_W'(TIMEOUT_CYCLES);

   logic [DIGITS-1:0]    anode_r, anode_p;
   logic [SEG_BUS_W-1:0] seg_r, seg_p;

   state_t state, state_nx;

   logic [STABLE_W-1:0] stable_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic [IDLE_W-1:0]   idle_nx_c;
   logic [DIGITS-1:0]   mask;
   digit_t [DIGITS-1:0] slots;

   logic sel_ok_c, same_c, anode_same_c, stable_done_c;
   logic capture_c, cnt_load_c, cnt_inc_c, frame_c;
   logic [DIGITS-1:0] cap_bits_c;

   logic [NIBBLE_W-1:0] dec_value_c;
   logic                dec_blank_c, dec_illegal_c;

   logic [DIGITS-1:0][NIBBLE_W-1:0] frame_data_c;
   logic [DIGITS-1:0]               frame_dp_c, frame_blank_c, frame_illegal_c;

   // Input stage plus one cycle of history for change detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode_r <= '1;
         seg_r   <= '1;
         anode_p <= '1;
         seg_p   <= '1;
      end else begin
         anode_r <= anode;
         seg_r   <= segment;
         anode_p <= anode_r;
         seg_p   <= seg_r;
      end
   end

   assign sel_ok_c      = sel_valid(anode_r);
   assign same_c        = ({anode_r, seg_r} == {anode_p, seg_p});
   assign anode_same_c  = (anode_r == anode_p);
   assign stable_done_c = (stable_cnt >= STABLE_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (sel_ok_c) state_nx = SETTLE;
         end
         SETTLE: begin
            if (same_c) begin
               if (stable_done_c) state_nx = HELD;
            end else if (!sel_ok_c) begin
               state_nx = IDLE;
            end
         end
         HELD: begin
            if (!anode_same_c) state_nx = sel_ok_c ? SETTLE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      capture_c  = 1'b0;
      cnt_load_c = 1'b0;
      cnt_inc_c  = 1'b0;
      case (state)
         IDLE: begin
            cnt_load_c = sel_ok_c;
         end
         SETTLE: begin
            if (same_c) begin
               cnt_inc_c = 1'b1;
               capture_c = stable_done_c;
            end else begin
               cnt_load_c = sel_ok_c;
            end
         end
         HELD: begin
            cnt_load_c = !anode_same_c && sel_ok_c;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                                 stable_cnt <= '0;
      else if (cnt_load_c)                       stable_cnt <= STABLE_W'(1);
      else if (cnt_inc_c && stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + STABLE_W'(1);
   end

   seven_segment_decode u_decode (
      .pattern (seg_r[SEG_G:SEG_A]),
      .value   (dec_value_c),
      .blank   (dec_blank_c),
      .illegal (dec_illegal_c)
   );

   // Capture only ever happens with a one-hot-low select, so ~anode_r is the slot bit.
   assign cap_bits_c = capture_c ? ~anode_r : '0;
   assign frame_c    = (mask == '1);

   always_ff @(posedge clk) begin
      if (reset) begin
         slots <= '0;
      end else begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cap_bits_c[IDX_W'(i)]) begin
               slots[IDX_W'(i)] <= '{value:   dec_value_c,
                                     dp:      ~seg_r[SEG_DP],
                                     blank:   dec_blank_c,
                                     illegal: dec_illegal_c};
            end
         end
      end
   end

   // A capture coinciding with the frame load seeds the next frame's mask.
   always_ff @(posedge clk) begin
      if (reset) mask <= '0;
      else       mask <= (frame_c ? '0 : mask) | cap_bits_c;
   end

   always_comb begin
      frame_data_c    = '0;
      frame_dp_c      = '0;
      frame_blank_c   = '0;
      frame_illegal_c = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         frame_data_c[IDX_W'(i)]    = slots[IDX_W'(i)].value;
         frame_dp_c[IDX_W'(i)]      = slots[IDX_W'(i)].dp;
         frame_blank_c[IDX_W'(i)]   = slots[IDX_W'(i)].blank;
         frame_illegal_c[IDX_W'(i)] = slots[IDX_W'(i)].illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dataOut    <= '0;
         pointOut   <= '0;
         blankOut   <= '0;
         illegalOut <= '0;
         frameValid <= 1'b0;
      end else begin
         frameValid <= frame_c;
         if (frame_c) begin
            dataOut    <= frame_data_c;
            pointOut   <= frame_dp_c;
            blankOut   <= frame_blank_c;
            illegalOut <= frame_illegal_c;
         end
      end
   end

   assign idle_nx_c = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);

   // Watchdog: saturating count of cycles since the last capture.
   always_ff @(posedge clk) begin
      if (reset || capture_c) begin
         idle_cnt <= '0;
         stalled  <= 1'b0;
      end else begin
         idle_cnt <= idle_nx_c;
         stalled  <= (idle_nx_c == IDLE_MAX);
      end
   end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receiving end of the multiplexed seven-segment interface: watches the anode/segment buses driven by SevenSegmentControl and recovers the four displayed hex digits, decimal points and blank status.
- Used as a bench monitor for stopwatch-style designs and in-FPGA loopback self-check.
- Filters switching ghosting, decodes active-low patterns and publishes one coherent 16-bit frame once every digit has been observed.

Parameters:
- STABLE_CYCLES, 16: consecutive identical registered samples required before a digit is captured (range 2..255).
- TIMEOUT_CYCLES, 1048576: cycles without a capture before stalled asserts.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- anode  input  4  active-low digit enables; anode[i] low selects digit i
- segment  input  8  active-low; segment[0..6]=a..g, segment[7]=dp
- dataOut  output  16  recovered digits; digit i in [4i+3:4i]
- pointOut  output  4  decimal point lit per digit
- blankOut  output  4  digit had all of a..g off
- illegalOut  output  4  digit pattern not in the hex table and not blank
- frameValid  output  1  one-cycle pulse when the frame outputs update
- stalled  output  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Input stage: anode and segment are registered once (anode_r, seg_r). All decisions use the registered values.
- Reset: all outputs are 0, the captured mask is 0, state is IDLE, and both counters are 0. Reset mid-frame discards partial captures.
- Valid select: anode_r is exactly one-hot-low (4'b1110, 1101, 1011, 0111). Any other value, including 4'b1111 and multiple lows, is "no select".
- FSM:
  - IDLE: on a valid select, go to SETTLE with stable_cnt=1.
  - SETTLE: while {anode_r, seg_r} is unchanged from the previous cycle, stable_cnt increments. When stable_cnt reaches STABLE_CYCLES, capture and go to HELD. Any change restarts the count at 1 if the select is still valid; otherwise go to IDLE.
  - HELD: while anode_r is unchanged, stay and do not recapture, even if seg_r changes. On an anode_r change, go to SETTLE (valid select) or IDLE.
- Capture of digit i:
  - Look up seg_r[6:0] in the hex table and store the value in slot i.
  - dp = ~seg_r[7].
  - blank = (seg_r[6:0]==7'h7F); the stored value is 0.
  - illegal = not in the table and not blank; the stored value is 0.
  - Set mask bit i. Recapturing a slot before the frame completes overwrites it.
- Frame:
  - In the cycle after mask becomes 4'b1111, dataOut/pointOut/blankOut/illegalOut load from the slots, frameValid pulses for 1 cycle, and the mask clears.
  - Outputs hold between frames.
  - A capture in the same cycle as the frame load sets its mask bit for the next frame and is not lost.
- Latency: the first capture occurs STABLE_CYCLES+1 cycles after stable inputs first reach the pins. frameValid follows the fourth capture by 1 cycle.
- Timeout: idle_cnt increments each cycle without a capture and saturates at TIMEOUT_CYCLES, at which point stalled=1. Any capture clears idle_cnt and stalled in the next cycle.
- Counters: stable_cnt is $clog2(STABLE_CYCLES+1) bits and saturating. idle_cnt is $clog2(TIMEOUT_CYCLES+1) bits and saturating.

Decomposition:
- Package sevenseg_pkg holds:
  - the segment bit-index constants;
  - SEG_BLANK=7'h7F;
  - the 16-entry active-low hex table, indexed 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E;
  - the FSM state enum {IDLE,SETTLE,HELD}.
- Sub-module seven_segment_decode is purely combinational: 7-bit pattern in, value[3:0]/blank/illegal out. It is shared with the display block's self-check.

Test Plan:
- Reset, then drive anode 1110/1101/1011/0111 with patterns 0x79,0x24,0x30,0x19, each held 20 cycles, dp off -> one frameValid, dataOut=16'h4321, pointOut=0, blankOut=0, illegalOut=0.
- Glitch: hold digit 0 with 0x40 for 10 cycles, then 0x79 for 20 cycles -> digit 0 captured as 1, not 0. A digit held only 15 cycles is never captured.
- Multi-low anode 4'b1100 for 100 cycles and 4'b1111 for 100 cycles -> no capture, no frameValid.
- Digit 2 pattern 0x7F with dp on, and digit 3 pattern 0x55 -> blankOut=4'b0100, illegalOut=4'b1000, pointOut=4'b0100, dataOut[15:8]=8'h00.
- Assert reset after three captures, release, then scan the full frame F,E,D,C on digits 0..3 -> the single frame after reset reports dataOut=16'hCDEF, and no stale digit appears.
- With TIMEOUT_CYCLES=64: no anode activity for 64 cycles -> stalled=1. Then a valid capture -> stalled=0 the cycle after the capture.
